// File: rtl/spi_ram_slave_param.sv
// SPI slave oversampled on clk, decoding 2-bit commands to access a RAM.
// Supports address range rejection, frame abort detection and burst pointers.
module spi_ram_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic frame_err
);

    localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(PW + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        READ_OUT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [1:0]            cmd_q;
    logic [CW-1:0]         cnt;
    logic [PW-2:0]         shreg;
    logic [PW-1:0]         payload;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr;
    logic                  in_range, wr_en;
    logic                  abort, exec, rd_start, shift, rd_done;

    function automatic logic [ADDR_WIDTH-1:0] bump(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign payload  = {shreg, mosi};
    assign addr     = payload[ADDR_WIDTH-1:0];
    assign in_range = {1'b0, addr} < DEPTH;
    assign mem_rd   = mem[rd_ptr];
    assign wr_en    = exec && (cmd_q == 2'b01);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ss_n high on what would be the completing edge still counts as abort
    always_comb begin
        state_d  = state_q;
        abort    = 1'b0;
        exec     = 1'b0;
        rd_start = 1'b0;
        shift    = 1'b0;
        rd_done  = 1'b0;
        unique case (state_q)
            IDLE: if (!ss_n) state_d = CMD;
            CMD: begin
                if (ss_n) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cmd_q[1] && mosi) begin
                    rd_start = 1'b1;
                    state_d  = READ_OUT;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (ss_n) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt == CW'(1)) begin
                    exec    = 1'b1;
                    state_d = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            READ_OUT: begin
                if (ss_n) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt == CW'(1)) begin
                    rd_done = 1'b1;
                    state_d = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: if (ss_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            cnt       <= '0;
            shreg     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state_q == IDLE && !ss_n) cmd_q[1] <= mosi;
            if (state_q == CMD && !ss_n) begin
                cmd_q[0] <= mosi;
                if (rd_start) begin
                    cnt   <= CW'(DATA_WIDTH);
                    shreg <= (PW - 1)'(mem_rd[DATA_WIDTH-2:0]);
                    miso  <= mem_rd[DATA_WIDTH-1];
                end else begin
                    cnt   <= CW'(PW);
                    shreg <= '0;
                end
            end
            if (shift) begin
                cnt <= cnt - CW'(1);
                if (state_q == PAYLOAD) begin
                    shreg <= payload[PW-2:0];
                end else begin
                    miso  <= shreg[DATA_WIDTH-2];
                    shreg <= shreg << 1;
                end
            end
            if (exec) begin
                case (cmd_q)
                    2'b00: begin
                        if (in_range) wr_ptr <= addr;
                        else          frame_err <= 1'b1;
                    end
                    2'b01: if (AUTO_INC != 0) wr_ptr <= bump(wr_ptr);
                    2'b10: begin
                        if (in_range) rd_ptr <= addr;
                        else          frame_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_done) begin
                miso <= 1'b0;
                if (AUTO_INC != 0) rd_ptr <= bump(rd_ptr);
            end
            if (abort) begin
                miso      <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= payload[DATA_WIDTH-1:0];
    end

endmodule
